// File: rtl/debug_capture.sv
// Debug overlay producer: filters CPU bus writes by address match/mask into a
// small FIFO and, once per frame at the vblank rising edge, latches one hit into o_debug.
module debug_capture #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic              i_wr,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_match_addr,
    input  logic [ADDR_W-1:0] i_match_mask,
    input  logic              i_vblank,
    input  logic              i_freeze,
    input  logic              i_clear,
    output logic [63:0]       o_debug,
    output logic [3:0]        o_level,
    output logic              o_overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0]     mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]        level_q, level_d;
    logic              wr_q, vb_q, armed_q;
    logic [15:0]       hit_q, hit_d;
    logic [7:0]        frame_q, frame_d;
    logic              overflow_q, overflow_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [63:0]       debug_q, debug_d;

    logic wr_edge, vb_edge, hit, update, pop, push, full;

    always_comb begin
        // armed_q masks the first cycle after reset so a level already high is absorbed, not seen as an edge
        wr_edge     = armed_q & i_wr & ~wr_q;
        vb_edge     = armed_q & i_vblank & ~vb_q;
        hit         = wr_edge & (((i_addr ^ i_match_addr) & i_match_mask) == '0);
        update      = vb_edge & ~i_freeze;
        pop         = update & (level_q != '0);
        full        = (level_q == 4'(DEPTH));
        push        = hit & (~full | pop);

        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        level_d     = level_q + {3'b000, push} - {3'b000, pop};
        hit_d       = hit_q;
        frame_d     = frame_q;
        overflow_d  = overflow_q;
        disp_addr_d = disp_addr_q;
        disp_data_d = disp_data_q;
        prev_d      = prev_q;
        debug_d     = debug_q;

        if (push) wptr_d = wptr_q + PW'(1);
        if (hit && hit_q != '1) hit_d = hit_q + 16'd1;
        if (hit && !push) overflow_d = 1'b1;
        if (pop) begin
            rptr_d      = rptr_q + PW'(1);
            disp_addr_d = mem_q[rptr_q][EW-1:DATA_W];
            disp_data_d = mem_q[rptr_q][DATA_W-1:0];
            prev_d      = disp_data_q;
        end
        if (update) begin
            frame_d = frame_q + 8'd1;
            debug_d = {frame_d, hit_d, disp_addr_d, disp_data_d, prev_d,
                       overflow_d, i_freeze, 2'b00, level_d};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {i_addr, i_data};
    end

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            wr_q        <= 1'b0;
            vb_q        <= 1'b0;
            armed_q     <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            level_q     <= '0;
            hit_q       <= '0;
            frame_q     <= '0;
            overflow_q  <= 1'b0;
            disp_addr_q <= '0;
            disp_data_q <= '0;
            prev_q      <= '0;
            debug_q     <= '0;
        end else begin
            wr_q    <= i_wr;
            vb_q    <= i_vblank;
            armed_q <= 1'b1;
            if (i_clear) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                level_q     <= '0;
                hit_q       <= '0;
                frame_q     <= '0;
                overflow_q  <= 1'b0;
                disp_addr_q <= '0;
                disp_data_q <= '0;
                prev_q      <= '0;
                debug_q     <= '0;
            end else begin
                wptr_q      <= wptr_d;
                rptr_q      <= rptr_d;
                level_q     <= level_d;
                hit_q       <= hit_d;
                frame_q     <= frame_d;
                overflow_q  <= overflow_d;
                disp_addr_q <= disp_addr_d;
                disp_data_q <= disp_data_d;
                prev_q      <= prev_d;
                debug_q     <= debug_d;
            end
        end
    end

    assign o_debug    = debug_q;
    assign o_level    = level_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_debug_capture.sv
// Directed bench for debug_capture: reset, hit filtering, overflow,
// push/pop collision, freeze and clear, against hand-computed debug words.
module tb_debug_capture;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_wr;
    logic [15:0] i_addr;
    logic [7:0]  i_data;
    logic [15:0] i_match_addr;
    logic [15:0] i_match_mask;
    logic        i_vblank;
    logic        i_freeze;
    logic        i_clear;
    logic [63:0] o_debug;
    logic [3:0]  o_level;
    logic        o_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    debug_capture #(.ADDR_W(16), .DATA_W(8), .DEPTH(8)) dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_wr         (i_wr),
        .i_addr       (i_addr),
        .i_data       (i_data),
        .i_match_addr (i_match_addr),
        .i_match_mask (i_match_mask),
        .i_vblank     (i_vblank),
        .i_freeze     (i_freeze),
        .i_clear      (i_clear),
        .o_debug      (o_debug),
        .o_level      (o_level),
        .o_overflow   (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        i_addr = a;
        i_data = d;
        i_wr   = 1'b1;
        tick();
        i_wr   = 1'b0;
        tick();
    endtask

    task automatic do_vblank();
        i_vblank = 1'b1;
        tick();
        i_vblank = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            i_wr     = i[0];
            i_vblank = i[1];
            tick();
        end
        n_checks++;
        if (o_debug !== 64'h0) begin n_fail++; $display("FAIL reset_debug got=%h exp=%h", o_debug, 64'h0); end
        n_checks++;
        if (o_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", o_level); end
        n_checks++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", o_overflow); end
        // release with vblank and a matching write both already high
        i_match_addr = 16'h0000;
        i_match_mask = 16'h0000;
        i_vblank = 1'b1;
        i_wr     = 1'b1;
        tick();
        i_reset_n = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (o_debug !== 64'h0) begin n_fail++; $display("FAIL reset_release_no_edge got=%h exp=%h", o_debug, 64'h0); end
        i_wr = 1'b0;
        tick();
        n_checks++;
        if (o_level !== 4'd0) begin n_fail++; $display("FAIL reset_release_no_wr got=%0d exp=0", o_level); end
        i_vblank = 1'b0;
        tick();
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h0100_0000_0000_0000) begin
            n_fail++; $display("FAIL reset_first_frame got=%h exp=%h", o_debug, 64'h0100_0000_0000_0000);
        end
    endtask

    task automatic test_single_hit();
        do_clear();
        i_match_addr = 16'hC000;
        i_match_mask = 16'hFF00;
        do_write(16'hC012, 8'h5A);
        n_checks++;
        if (o_level !== 4'd1) begin n_fail++; $display("FAIL hit_level got=%0d exp=1", o_level); end
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h01_0001_C012_5A_00_00) begin
            n_fail++; $display("FAIL hit_debug got=%h exp=%h", o_debug, 64'h01_0001_C012_5A_00_00);
        end
        do_write(16'hD012, 8'h77);
        n_checks++;
        if (o_level !== 4'd0) begin n_fail++; $display("FAIL miss_level got=%0d exp=0", o_level); end
        n_checks++;
        if (o_debug !== 64'h01_0001_C012_5A_00_00) begin
            n_fail++; $display("FAIL debug_stable got=%h exp=%h", o_debug, 64'h01_0001_C012_5A_00_00);
        end
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h02_0001_C012_5A_00_00) begin
            n_fail++; $display("FAIL miss_empty_hold got=%h exp=%h", o_debug, 64'h02_0001_C012_5A_00_00);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        i_match_addr = 16'h0000;
        i_match_mask = 16'h0000;
        for (int i = 0; i < 9; i++) do_write(16'(i), 8'(8'h10 + i));
        n_checks++;
        if (o_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got=%0d exp=8", o_level); end
        n_checks++;
        if (o_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h01_0009_0000_10_00_87) begin
            n_fail++; $display("FAIL ovf_debug got=%h exp=%h", o_debug, 64'h01_0009_0000_10_00_87);
        end
        n_checks++;
        if (o_level !== 4'd7) begin n_fail++; $display("FAIL ovf_level_after got=%0d exp=7", o_level); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        i_match_mask = 16'h0000;
        for (int i = 0; i < 8; i++) do_write(16'(16'h0100 + i), 8'(8'h20 + i));
        i_addr   = 16'h0200;
        i_data   = 8'h77;
        i_wr     = 1'b1;
        i_vblank = 1'b1;
        tick();
        i_wr     = 1'b0;
        i_vblank = 1'b0;
        tick();
        n_checks++;
        if (o_level !== 4'd8) begin n_fail++; $display("FAIL pp_level got=%0d exp=8", o_level); end
        n_checks++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL pp_overflow got=%b exp=0", o_overflow); end
        n_checks++;
        if (o_debug !== 64'h01_0009_0100_20_00_08) begin
            n_fail++; $display("FAIL pp_debug got=%h exp=%h", o_debug, 64'h01_0009_0100_20_00_08);
        end
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h02_0009_0101_21_20_07) begin
            n_fail++; $display("FAIL pp_next_pop got=%h exp=%h", o_debug, 64'h02_0009_0101_21_20_07);
        end
    endtask

    task automatic test_freeze();
        do_clear();
        i_match_mask = 16'h0000;
        for (int i = 0; i < 3; i++) do_write(16'(16'hA000 + i), 8'(1 + i));
        i_freeze = 1'b1;
        tick();
        do_vblank();
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h0) begin n_fail++; $display("FAIL frz_debug got=%h exp=%h", o_debug, 64'h0); end
        n_checks++;
        if (o_level !== 4'd3) begin n_fail++; $display("FAIL frz_level got=%0d exp=3", o_level); end
        i_freeze = 1'b0;
        tick();
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h01_0003_A000_01_00_02) begin
            n_fail++; $display("FAIL frz_release got=%h exp=%h", o_debug, 64'h01_0003_A000_01_00_02);
        end
    endtask

    task automatic test_clear();
        do_clear();
        i_match_mask = 16'h0000;
        for (int i = 0; i < 9; i++) do_write(16'(16'h0300 + i), 8'(8'h40 + i));
        repeat (3) do_vblank();
        n_checks++;
        if (o_level !== 4'd5 || o_overflow !== 1'b1) begin
            n_fail++; $display("FAIL clr_setup got=%0d/%b exp=5/1", o_level, o_overflow);
        end
        i_addr  = 16'h0400;
        i_data  = 8'hEE;
        i_wr    = 1'b1;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        tick();
        i_wr    = 1'b0;
        tick();
        n_checks++;
        if (o_debug !== 64'h0) begin n_fail++; $display("FAIL clr_debug got=%h exp=%h", o_debug, 64'h0); end
        n_checks++;
        if (o_level !== 4'd0) begin n_fail++; $display("FAIL clr_level got=%0d exp=0", o_level); end
        n_checks++;
        if (o_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got=%b exp=0", o_overflow); end
        do_vblank();
        n_checks++;
        if (o_debug !== 64'h0100_0000_0000_0000) begin
            n_fail++; $display("FAIL clr_lost_edge got=%h exp=%h", o_debug, 64'h0100_0000_0000_0000);
        end
    endtask

    initial begin
        i_reset_n    = 1'b0;
        i_wr         = 1'b0;
        i_addr       = '0;
        i_data       = '0;
        i_match_addr = '0;
        i_match_mask = '0;
        i_vblank     = 1'b0;
        i_freeze     = 1'b0;
        i_clear      = 1'b0;
        test_reset();
        test_single_hit();
        test_overflow();
        test_back_to_back();
        test_freeze();
        test_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
